// File: rtl/reg_dump_sender.sv
// reg_dump_sender: walks a register file and streams it out as one byte frame:
// HEADER, each register's 4 bytes LSB first, then the XOR of all data bytes.
//
// Handshake (tx side): a byte moves on a rising edge where tx_valid=1 and
// tx_ready=1. Once tx_valid is raised, tx_valid and tx_data are held steady
// until that transfer happens; tx_ready has no effect while tx_valid=0.
module reg_dump_sender #(
  parameter int unsigned NUM_REGS = 32,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_value,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FETCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] value_q, value_d;
  logic        tx_valid_d;
  logic [7:0]  tx_data_d;
  logic [1:0]  next_byte;
  logic [31:0] shifted;
  logic        xfer;

  assign xfer      = tx_valid && tx_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign reg_sel   = (state_q == ST_FETCH) ? index_q : 5'd0;
  assign dbg_state = state_q;

  // Next-state logic; tx_valid/tx_data are computed one edge ahead so the
  // registered copies line up with the state that owns the byte.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    byte_d     = byte_q;
    csum_d     = csum_q;
    value_d    = value_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    next_byte  = byte_q + 2'd1;
    shifted    = value_q >> {next_byte, 3'b000};
    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        if (start) begin
          state_d    = ST_HEADER;
          csum_d     = 8'd0;
          index_d    = 5'd0;
          byte_d     = 2'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          state_d    = ST_FETCH;
          tx_valid_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // reg_value is combinational from reg_sel, so capture it now.
        value_d    = reg_value;
        byte_d     = 2'd0;
        state_d    = ST_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = reg_value[7:0];
      end
      ST_SEND: begin
        if (xfer) begin
          csum_d = csum_q ^ tx_data;
          if (byte_q == 2'd3) begin
            if (index_q == LAST_IDX) begin
              state_d    = ST_CHECK;
              tx_valid_d = 1'b1;
              tx_data_d  = csum_q ^ tx_data;
            end else begin
              state_d    = ST_FETCH;
              index_d    = index_q + 5'd1;
              tx_valid_d = 1'b0;
            end
          end else begin
            byte_d    = next_byte;
            tx_data_d = shifted[7:0];
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          state_d    = ST_DONE;
          tx_valid_d = 1'b0;
        end
      end
      ST_DONE: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over start and tx_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      index_q  <= 5'd0;
      byte_q   <= 2'd0;
      csum_q   <= 8'd0;
      value_q  <= 32'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      byte_q   <= byte_d;
      csum_q   <= csum_d;
      value_q  <= value_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_sender.sv
// Testbench for reg_dump_sender: 32-register frame plus a 1-register instance.
module tb_reg_dump_sender;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT (NUM_REGS = 32) ----------------
  logic        start = 1'b0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_value;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, done;
  logic [2:0]  dbg_state;
  logic [31:0] regs [32];

  assign reg_value = regs[reg_sel];

  reg_dump_sender #(.NUM_REGS(32), .HEADER(8'hA5)) dut (
    .clock(clock), .reset(reset), .start(start), .reg_sel(reg_sel),
    .reg_value(reg_value), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- DUT (NUM_REGS = 1) ----------------
  logic        start1 = 1'b0;
  logic [4:0]  reg_sel1;
  logic [31:0] reg_value1;
  logic [7:0]  tx_data1;
  logic        tx_valid1;
  logic        tx_ready1 = 1'b1;
  logic        busy1, done1;
  logic [2:0]  dbg_state1;

  assign reg_value1 = (reg_sel1 == 5'd0) ? 32'h12345678 : 32'd0;

  reg_dump_sender #(.NUM_REGS(1), .HEADER(8'hA5)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .reg_sel(reg_sel1),
    .reg_value(reg_value1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .busy(busy1), .done(done1), .dbg_state(dbg_state1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int         xfer_cnt = 0;
  int         stall_cycles = 0;
  logic [7:0] stall_byte = 8'h00;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  // Sample between edges: a transfer happens at the next posedge when valid&ready.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
        check("stall_data_held", {24'd0, tx_data}, {24'd0, stall_data});
      end
      if (tx_valid && tx_ready) begin
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check($sformatf("byte%0d", xfer_cnt), {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        xfer_cnt++;
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && !tx_ready) begin
        stall_cycles++;
        stall_byte = tx_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame();
    logic [7:0] csum;
    logic [31:0] v;
    csum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      v = regs[i];
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(v[8*k +: 8]);
        csum = csum ^ v[8*k +: 8];
      end
    end
    exp_q.push_back(csum);
  endtask

  task automatic run_frame(input int stall_at, input int restart_at, input bit start_in_done,
                           output int busy_cnt, output int done_at);
    int  cyc;
    int  stall_left;
    bit  stalled;
    bit  restarted;
    busy_cnt = 0; done_at = 0; cyc = 0; stall_left = 0; stalled = 0; restarted = 0;
    xfer_cnt = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("tx_valid_after_start", {31'd0, tx_valid}, 32'd1);
    check("header_byte", {24'd0, tx_data}, 32'hA5);
    while (done_at == 0 && cyc < 2000) begin
      if (busy) busy_cnt++;
      start = 1'b0;
      if (done) begin
        done_at = busy_cnt;
        if (start_in_done) start = 1'b1;
      end
      if (restart_at >= 0 && !restarted && xfer_cnt == restart_at && tx_valid) begin
        start = 1'b1;
        restarted = 1;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tx_ready = 1'b1;
      end else if (!stalled && stall_at >= 0 && xfer_cnt == stall_at && tx_valid) begin
        tx_ready = 1'b0;
        stall_left = 7;
        stalled = 1;
      end
      if (done_at == 0) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    check("done_seen", {31'd0, done_at != 0}, 32'd1);
    @(posedge clock); #1 start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_low_after_done", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  int bc, da;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1]  = 32'd10;
    regs[3]  = 32'd15;
    regs[5]  = 32'hFFFF_FFFB;
    regs[6]  = 32'd12;
    regs[15] = 32'd11111;

    // Reset state
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Full frame, content and timing
    push_frame();
    run_frame(-1, -1, 1'b0, bc, da);
    check("busy_cycles", bc, 32'd163);
    check("done_position", da, 32'd163);

    // Backpressure on byte 2 of r5 (frame byte 23)
    push_frame();
    stall_cycles = 0;
    run_frame(23, -1, 1'b0, bc, da);
    check("stall_cycles", stall_cycles, 32'd7);
    check("stall_byte", {24'd0, stall_byte}, 32'hFF);
    check("busy_cycles_stalled", bc, 32'd170);

    // start during frame and in DONE must be ignored
    push_frame();
    run_frame(-1, 50, 1'b1, bc, da);
    check("busy_cycles_restart", bc, 32'd163);

    // Reset during SEND of r6 (frame byte 26 = r6 byte 1)
    push_frame();
    xfer_cnt = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 400 && !(xfer_cnt == 26 && tx_valid); i++) begin
      @(posedge clock); #1;
    end
    check("reached_r6", xfer_cnt, 32'd26);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_reg_sel", {27'd0, reg_sel}, 32'd0);
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clock);
    #1;
    push_frame();
    run_frame(-1, -1, 1'b0, bc, da);
    check("busy_cycles_after_rst", bc, 32'd163);

    // NUM_REGS = 1 instance
    exp1_q.push_back(8'hA5);
    exp1_q.push_back(8'h78);
    exp1_q.push_back(8'h56);
    exp1_q.push_back(8'h34);
    exp1_q.push_back(8'h12);
    exp1_q.push_back(8'h08);
    @(posedge clock); #1 start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
    begin
      bit seen_done;
      seen_done = 0;
      for (int i = 0; i < 50 && !seen_done; i++) begin
        @(negedge clock);
        if (tx_valid1 && tx_ready1) begin
          check("n1_byte_expected", {31'd0, exp1_q.size() != 0}, 32'd1);
          if (exp1_q.size() != 0) check("n1_byte", {24'd0, tx_data1}, {24'd0, exp1_q.pop_front()});
        end
        if (done1) seen_done = 1;
      end
      check("n1_done_seen", {31'd0, seen_done}, 32'd1);
      check("n1_queue_drained", exp1_q.size(), 32'd0);
      @(negedge clock);
      check("n1_done_pulse", {31'd0, done1}, 32'd0);
      check("n1_busy_low", {31'd0, busy1}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
